// File: rtl/usb_msd_pkg.sv
// Shared types and constants for the MSD bulk-IN datapath.
package usb_msd_pkg;

    localparam int XFER_LEN_W = 16;

    localparam logic SRC_PROTO = 1'b0;
    localparam logic SRC_SD    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_SEND,
        ST_WAIT_ACK
    } pkt_state_t;

endpackage

// File: rtl/usb_msd_bulk_in_packetizer.sv
// Splits a transfer from one TX FIFO into bulk-IN packets of at most MAX_PKT bytes.
// Latency: first byte 2 cycles after start when data is present; 1 byte/cycle inside a packet.
// Backpressure: a packet starts only once fully buffered, so it stalls only on pkt_ready_i.
module usb_msd_bulk_in_packetizer
    import usb_msd_pkg::*;
#(
    parameter int TX_DPTH_W    = 8,
    parameter int TX_SD_DPTH_W = 8,
    parameter int MAX_PKT      = 64
) (
    input  logic                    usb_clk60_i,
    input  logic                    usb_rst_n_i,
    input  logic                    start_i,
    input  logic [XFER_LEN_W-1:0]   len_i,
    input  logic                    src_sd_i,
    input  logic                    abort_i,
    input  logic [7:0]              tx_rdat_i,
    input  logic                    tx_rempty_i,
    input  logic [TX_DPTH_W:0]      tx_rnum_i,
    output logic                    tx_rena_o,
    input  logic [7:0]              tx_sd_rdat_i,
    input  logic                    tx_sd_rempty_i,
    input  logic [TX_SD_DPTH_W:0]   tx_sd_rnum_i,
    output logic                    tx_sd_rena_o,
    output logic                    pkt_valid_o,
    output logic [7:0]              pkt_data_o,
    output logic                    pkt_last_o,
    input  logic                    pkt_ready_i,
    input  logic                    pkt_ack_i,
    output logic                    pkt_abort_o,
    output logic                    busy_o,
    output logic [XFER_LEN_W-1:0]   bytes_left_o,
    output logic                    done_stb_o
);

    localparam int MIN_DPTH_W = (TX_DPTH_W < TX_SD_DPTH_W) ? TX_DPTH_W : TX_SD_DPTH_W;

    generate
        if (MAX_PKT < 1 || MAX_PKT > (1 << MIN_DPTH_W)) begin : g_bad_max_pkt
            $error("MAX_PKT must be in 1 .. 2**min(TX_DPTH_W, TX_SD_DPTH_W)");
        end
    endgenerate

    localparam logic [XFER_LEN_W-1:0] MAX_PKT_L = XFER_LEN_W'(MAX_PKT);

    pkt_state_t              state;
    logic [XFER_LEN_W-1:0]   left;
    logic [XFER_LEN_W-1:0]   cnt;
    logic                    src;
    logic                    done_stb;
    logic                    pkt_abort;

    logic [7:0]              sel_rdat;
    logic                    sel_rempty;
    logic [XFER_LEN_W-1:0]   sel_rnum;
    logic [XFER_LEN_W-1:0]   plen;
    logic                    in_send;
    logic                    pkt_valid;
    logic                    beat;

    always_comb begin
        sel_rdat   = tx_rdat_i;
        sel_rempty = tx_rempty_i;
        sel_rnum   = XFER_LEN_W'(tx_rnum_i);
        if (src == SRC_SD) begin
            sel_rdat   = tx_sd_rdat_i;
            sel_rempty = tx_sd_rempty_i;
            sel_rnum   = XFER_LEN_W'(tx_sd_rnum_i);
        end
    end

    assign plen      = (left < MAX_PKT_L) ? left : MAX_PKT_L;
    assign in_send   = (state == ST_SEND);
    // rnum never over-reports, so rempty is only a guard against a misbehaving FIFO
    assign pkt_valid = in_send & ~sel_rempty;
    assign beat      = pkt_valid & pkt_ready_i;

    assign pkt_valid_o  = pkt_valid;
    assign pkt_data_o   = in_send ? sel_rdat : 8'h00;
    assign pkt_last_o   = in_send && (cnt == 16'd1);
    assign tx_rena_o    = beat && (src == SRC_PROTO);
    assign tx_sd_rena_o = beat && (src == SRC_SD);
    assign busy_o       = (state != ST_IDLE);
    assign bytes_left_o = left;
    assign done_stb_o   = done_stb;
    assign pkt_abort_o  = pkt_abort;

    always_ff @(posedge usb_clk60_i or negedge usb_rst_n_i) begin
        if (!usb_rst_n_i) begin
            state     <= ST_IDLE;
            left      <= '0;
            cnt       <= '0;
            src       <= SRC_PROTO;
            done_stb  <= 1'b0;
            pkt_abort <= 1'b0;
        end else begin
            done_stb  <= 1'b0;
            pkt_abort <= 1'b0;
            if (abort_i) begin
                state     <= ST_IDLE;
                left      <= '0;
                cnt       <= '0;
                pkt_abort <= (state == ST_SEND);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            left <= len_i;
                            src  <= src_sd_i;
                            // zero-length transfer completes without a ZLP
                            if (len_i == '0) begin
                                done_stb <= 1'b1;
                            end else begin
                                state <= ST_WAIT_DATA;
                            end
                        end
                    end
                    ST_WAIT_DATA: begin
                        if (sel_rnum >= plen) begin
                            cnt   <= plen;
                            state <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (beat) begin
                            cnt  <= cnt - 16'd1;
                            left <= left - 16'd1;
                            if (cnt == 16'd1) begin
                                state <= ST_WAIT_ACK;
                            end
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (pkt_ack_i) begin
                            if (left == '0) begin
                                done_stb <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                state <= ST_WAIT_DATA;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_msd_bulk_in_packetizer.sv
// Directed bench for the bulk-IN packetizer with behavioural FIFO models.
module tb_usb_msd_bulk_in_packetizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] len;
    logic        src_sd;
    logic        abort;
    logic [7:0]  tx_rdat;
    logic        tx_rempty;
    logic [8:0]  tx_rnum;
    logic        tx_rena;
    logic [7:0]  sd_rdat;
    logic        sd_rempty;
    logic [8:0]  sd_rnum;
    logic        sd_rena;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        ready;
    logic        ack;
    logic        pkt_abort;
    logic        busy;
    logic [15:0] bytes_left;
    logic        done;

    always #5 clk = ~clk;

    usb_msd_bulk_in_packetizer #(
        .TX_DPTH_W(8), .TX_SD_DPTH_W(8), .MAX_PKT(64)
    ) dut (
        .usb_clk60_i(clk), .usb_rst_n_i(rst_n),
        .start_i(start), .len_i(len), .src_sd_i(src_sd), .abort_i(abort),
        .tx_rdat_i(tx_rdat), .tx_rempty_i(tx_rempty), .tx_rnum_i(tx_rnum), .tx_rena_o(tx_rena),
        .tx_sd_rdat_i(sd_rdat), .tx_sd_rempty_i(sd_rempty), .tx_sd_rnum_i(sd_rnum), .tx_sd_rena_o(sd_rena),
        .pkt_valid_o(valid), .pkt_data_o(data), .pkt_last_o(last), .pkt_ready_i(ready),
        .pkt_ack_i(ack), .pkt_abort_o(pkt_abort),
        .busy_o(busy), .bytes_left_o(bytes_left), .done_stb_o(done)
    );

    // Fall-through FIFO models: pushes from the stimulus, pops on rena.
    logic [7:0] proto_mem [0:255];
    logic [7:0] sd_mem    [0:255];
    int proto_wp = 0, proto_rp = 0, sd_wp = 0, sd_rp = 0;

    assign tx_rnum   = 9'(proto_wp - proto_rp);
    assign tx_rempty = (proto_wp == proto_rp);
    assign tx_rdat   = proto_mem[proto_rp[7:0]];
    assign sd_rnum   = 9'(sd_wp - sd_rp);
    assign sd_rempty = (sd_wp == sd_rp);
    assign sd_rdat   = sd_mem[sd_rp[7:0]];

    always @(posedge clk) begin
        if (tx_rena) proto_rp <= proto_rp + 1;
        if (sd_rena) sd_rp <= sd_rp + 1;
    end

    // Stream monitor
    logic [7:0] rx [0:1023];
    int rx_n = 0, pkt_n = 0, cur_len = 0, last_idx = -1;
    int pkt_len [0:31];
    int first_rnum [0:31];
    int proto_rena_cnt = 0, sd_rena_cnt = 0, drop_cnt = 0, done_cnt = 0, abort_cnt = 0;
    logic in_pkt = 1'b0;
    logic mon_src = 1'b0;

    always @(posedge clk) begin
        if (tx_rena) proto_rena_cnt <= proto_rena_cnt + 1;
        if (sd_rena) sd_rena_cnt <= sd_rena_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (pkt_abort) abort_cnt <= abort_cnt + 1;
        if (in_pkt && !valid && !pkt_abort) drop_cnt <= drop_cnt + 1;
        if (valid && ready) begin
            rx[rx_n] <= data;
            rx_n <= rx_n + 1;
            if (cur_len == 0) first_rnum[pkt_n] <= mon_src ? int'(sd_rnum) : int'(tx_rnum);
            if (last) begin
                pkt_len[pkt_n] <= cur_len + 1;
                pkt_n <= pkt_n + 1;
                cur_len <= 0;
                last_idx <= rx_n;
                in_pkt <= 1'b0;
            end else begin
                cur_len <= cur_len + 1;
                in_pkt <= 1'b1;
            end
        end
        if (abort || !rst_n) begin
            cur_len <= 0;
            in_pkt <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_proto(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            proto_mem[proto_wp[7:0]] = first + 8'(i);
            proto_wp = proto_wp + 1;
        end
    endtask

    task automatic push_sd(input logic [7:0] b);
        sd_mem[sd_wp[7:0]] = b;
        sd_wp = sd_wp + 1;
    endtask

    task automatic do_start(input logic [15:0] l, input logic s);
        start = 1'b1;
        len = l;
        src_sd = s;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_pkts(input string tag, input int target, input int budget);
        int n = 0;
        while (pkt_n < target && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(pkt_n >= target), 32'd1);
    endtask

    function automatic int order_err(input int base, input int n, input logic [7:0] first);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (rx[base + i] !== 8'(first + 8'(i))) e++;
        return e;
    endfunction

    int b_rx, b_pkt, b_prena, b_srena, b_done, b_abort, b_drop;

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; src_sd = 1'b0; abort = 1'b0;
        ready = 1'b0; ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_valid", 32'(valid), 0);
        check_eq("rst_left", 32'(bytes_left), 0);
        check_eq("rst_strobes", {28'd0, done, pkt_abort, tx_rena, sd_rena}, 0);
        rst_n = 1'b1;
        tick();

        // 13-byte transfer from the protocol FIFO
        push_proto(13, 8'h10);
        ready = 1'b1; mon_src = 1'b0;
        b_rx = rx_n; b_pkt = pkt_n;
        do_start(16'd13, 1'b0);
        check_eq("t1_valid_c1", 32'(valid), 0);
        check_eq("t1_left", 32'(bytes_left), 13);
        tick();
        check_eq("t1_valid_c2", 32'(valid), 1);
        check_eq("t1_first_dat", 32'(data), 32'h10);
        wait_pkts("t1_pkt_seen", b_pkt + 1, 100);
        check_eq("t1_len", pkt_len[b_pkt], 13);
        check_eq("t1_last_idx", last_idx, b_rx + 12);
        check_eq("t1_order", order_err(b_rx, 13, 8'h10), 0);
        check_eq("t1_no_early_done", 32'(done), 0);
        pulse_ack();
        check_eq("t1_done", 32'(done), 1);
        check_eq("t1_idle", 32'(busy), 0);
        tick();
        check_eq("t1_done_single", 32'(done), 0);

        // 150 bytes from the SD FIFO trickling in at 1 byte per 4 cycles
        mon_src = 1'b1;
        b_rx = rx_n; b_pkt = pkt_n; b_prena = proto_rena_cnt; b_srena = sd_rena_cnt;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    push_sd(8'h80 + 8'(i));
                    repeat (4) tick();
                end
            end
            begin
                do_start(16'd150, 1'b1);
                wait_pkts("t2_pkt0_seen", b_pkt + 1, 1500);
                pulse_ack();
                wait_pkts("t2_pkt1_seen", b_pkt + 2, 1500);
                pulse_ack();
                wait_pkts("t2_pkt2_seen", b_pkt + 3, 1500);
            end
        join
        pulse_ack();
        check_eq("t2_done", 32'(done), 1);
        check_eq("t2_len0", pkt_len[b_pkt], 64);
        check_eq("t2_len1", pkt_len[b_pkt + 1], 64);
        check_eq("t2_len2", pkt_len[b_pkt + 2], 22);
        check_eq("t2_buffered0", 32'(first_rnum[b_pkt] >= 64), 1);
        check_eq("t2_buffered1", 32'(first_rnum[b_pkt + 1] >= 64), 1);
        check_eq("t2_buffered2", 32'(first_rnum[b_pkt + 2] >= 22), 1);
        check_eq("t2_order", order_err(b_rx, 150, 8'h80), 0);
        check_eq("t2_proto_rena", proto_rena_cnt - b_prena, 0);
        check_eq("t2_sd_rena", sd_rena_cnt - b_srena, 150);

        // 64-byte packet with random backpressure
        push_proto(64, 8'h20);
        mon_src = 1'b0;
        b_rx = rx_n; b_pkt = pkt_n; b_prena = proto_rena_cnt; b_drop = drop_cnt;
        do_start(16'd64, 1'b0);
        for (int n = 0; n < 600 && pkt_n < b_pkt + 1; n++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        ready = 1'b1;
        check_eq("t3_pkt_seen", 32'(pkt_n >= b_pkt + 1), 1);
        check_eq("t3_len", pkt_len[b_pkt], 64);
        check_eq("t3_order", order_err(b_rx, 64, 8'h20), 0);
        check_eq("t3_rena", proto_rena_cnt - b_prena, 64);
        check_eq("t3_no_drop", drop_cnt - b_drop, 0);
        pulse_ack();
        check_eq("t3_done", 32'(done), 1);
        tick();

        // zero length, then start/abort while waiting for data
        do_start(16'd0, 1'b0);
        check_eq("t4_zlen_done", 32'(done), 1);
        check_eq("t4_zlen_busy", 32'(busy), 0);
        check_eq("t4_zlen_valid", 32'(valid), 0);
        tick();
        check_eq("t4_zlen_single", 32'(done), 0);
        do_start(16'd40, 1'b1);
        check_eq("t4_busy", 32'(busy), 1);
        check_eq("t4_left", 32'(bytes_left), 40);
        do_start(16'd7, 1'b0);
        check_eq("t4_start_ignored", 32'(bytes_left), 40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t4_abort_idle", 32'(busy), 0);
        check_eq("t4_abort_left", 32'(bytes_left), 0);
        check_eq("t4_no_pkt_abort", 32'(pkt_abort), 0);
        check_eq("t4_no_done", 32'(done), 0);

        // abort on byte 20 of a 64-byte packet
        push_proto(64, 8'h40);
        b_rx = rx_n; b_prena = proto_rena_cnt; b_done = done_cnt; b_abort = abort_cnt;
        do_start(16'd64, 1'b0);
        for (int n = 0; n < 100 && (rx_n - b_rx) < 19; n++) tick();
        check_eq("t5_byte20", 32'(data), 32'h53);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t5_pkt_abort", 32'(pkt_abort), 1);
        check_eq("t5_idle", 32'(busy), 0);
        check_eq("t5_left", 32'(bytes_left), 0);
        check_eq("t5_valid", 32'(valid), 0);
        tick();
        check_eq("t5_abort_single", 32'(pkt_abort), 0);
        check_eq("t5_abort_cnt", abort_cnt - b_abort, 1);
        check_eq("t5_no_done", done_cnt - b_done, 0);
        check_eq("t5_rena", proto_rena_cnt - b_prena, 20);

        // asynchronous reset mid-packet (44 bytes left in the protocol FIFO)
        do_start(16'd30, 1'b0);
        tick();
        tick();
        check_eq("t6_sending", 32'(valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 32'(valid), 0);
        check_eq("t6_data_last", {23'd0, data, last}, 0);
        check_eq("t6_busy", 32'(busy), 0);
        check_eq("t6_left", 32'(bytes_left), 0);
        check_eq("t6_strobes", {28'd0, done, pkt_abort, tx_rena, sd_rena}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check_eq("t6_idle_after", 32'(busy), 0);
        check_eq("t6_valid_after", 32'(valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
